// File: rtl/latch_capture_ctrl_pkg.sv
// latch_ctrl_pkg: shared types and constants for the latch capture controller.
//   state_e     - controller FSM states
//   Def*        - default data width and window lengths (cycles)
//   cnt_width() - width of the window down-counter for a given set of windows
package latch_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StOpen,
        StHold
    } state_e;

    localparam int DefWidth    = 8;
    localparam int DefSetupCyc = 1;
    localparam int DefOpenCyc  = 2;
    localparam int DefHoldCyc  = 1;

    // The counter only ever holds (window - 1), so $clog2 of the longest window
    // is enough. It never shrinks below one bit so the ports stay legal.
    function automatic int cnt_width(input int s, input int o, input int h);
        int m;
        m = s;
        if (o > m) m = o;
        if (h > m) m = h;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/latch_capture_ctrl_cyc_timer.sv
// cyc_timer: loadable down-counter with a zero flag, shared by the setup,
// open and hold windows.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - load load_val this cycle (takes priority over counting)
//   load_val   - value to load
//   zero       - counter currently holds zero
module cyc_timer #(
    parameter int unsigned CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at zero so the counter sits still while the controller idles.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/latch_capture_ctrl.sv
// latch_capture_ctrl: drives the D bus and enable of a bank of transparent
// latches. A word accepted over valid/ready is presented on D, then En is
// opened after a setup window and closed before a hold window, so D is never
// changing around an En edge. done pulses for one cycle at the end of hold.
//   clk, rst_n         - clock, asynchronous active-low reset
//   in_valid/in_ready  - input handshake; in_data is the word to latch
//   abort              - close the latch early (only acted on in setup/open)
//   D, En              - registered latch data bus and enable
//   busy               - a window is in progress
//   done, aborted      - end-of-window pulse; aborted marks a cut-short window
module latch_capture_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int WIDTH     = DefWidth,
    parameter int SETUP_CYC = DefSetupCyc,
    parameter int OPEN_CYC  = DefOpenCyc,
    parameter int HOLD_CYC  = DefHoldCyc
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic [WIDTH-1:0] D,
    output logic             En,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int CW = cnt_width(SETUP_CYC, OPEN_CYC, HOLD_CYC);

    if (SETUP_CYC < 1 || OPEN_CYC < 1 || HOLD_CYC < 1) begin : g_param_err
        $error("latch_capture_ctrl: SETUP_CYC, OPEN_CYC and HOLD_CYC must be >= 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             en_q, en_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abt_out_q, abt_out_d;
    logic             abt_seen_q, abt_seen_d;
    logic             xfer;
    logic             tmr_load;
    logic [CW-1:0]    tmr_val;
    logic             tmr_zero;

    // rdy_q is only ever set while idle, so this is the idle handshake.
    assign xfer = in_valid && rdy_q;

    cyc_timer #(
        .CW(CW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            d_q        <= '0;
            en_q       <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abt_out_q  <= 1'b0;
            abt_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            en_q       <= en_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abt_out_q  <= abt_out_d;
            abt_seen_q <= abt_seen_d;
        end
    end

    // Next state and window timer loads.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    state_d  = StSetup;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(SETUP_CYC - 1);
                end
            end
            StSetup: begin
                if (abort) begin
                    state_d  = StHold;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(HOLD_CYC - 1);
                end else if (tmr_zero) begin
                    state_d  = StOpen;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(OPEN_CYC - 1);
                end
            end
            StOpen: begin
                // Abort on the final open cycle lands in the same hold window.
                if (abort || tmr_zero) begin
                    state_d  = StHold;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(HOLD_CYC - 1);
                end
            end
            StHold: begin
                if (tmr_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, all derived from the next state.
    always_comb begin
        d_d        = xfer ? in_data : d_q;
        en_d       = (state_d == StOpen);
        rdy_d      = (state_d == StIdle);
        busy_d     = (state_d != StIdle);
        done_d     = (state_q == StHold) && (state_d == StIdle);
        abt_seen_d = abt_seen_q;
        if (xfer) begin
            abt_seen_d = 1'b0;
        end else if (abort && (state_q == StSetup || state_q == StOpen)) begin
            abt_seen_d = 1'b1;
        end
        abt_out_d = done_d && abt_seen_q;
    end

    assign D        = d_q;
    assign En       = en_q;
    assign in_ready = rdy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = abt_out_q;

endmodule
